// File: rtl/m68k_bus_pkg.sv
// Shared encodings for the 68040 single-transfer bus initiator:
// transfer sizes, attribute codes and the master FSM state set.
package m68k_bus_pkg;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  localparam logic [1:0] TT_NORMAL = 2'b00;

  localparam logic [2:0] TM_USER_DATA = 3'b001;
  localparam logic [2:0] TM_USER_CODE = 3'b010;
  localparam logic [2:0] TM_SUPV_DATA = 3'b101;
  localparam logic [2:0] TM_SUPV_CODE = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_DATA,
    S_END,
    S_FAIL
  } state_t;

endpackage

// File: rtl/m68k_lane_map.sv
// Byte-lane mapping: sel -> (legal, siz, a[1:0]), write replication,
// read extraction. Lane 0 is D31:24 (sel[3]).
module m68k_lane_map
  import m68k_bus_pkg::*;
(
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic        legal,
  output logic [1:0]  siz,
  output logic [1:0]  a_lo,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] mask;

  always_comb begin
    legal     = 1'b1;
    siz       = SIZ_LONG;
    a_lo      = 2'b00;
    wdata_rep = wdata;
    unique case (1'b1)
      (sel == 4'b1111): legal = 1'b1;
      (sel == 4'b1100): begin
        siz       = SIZ_WORD;
        wdata_rep = {2{wdata[31:16]}};
      end
      (sel == 4'b0011): begin
        siz       = SIZ_WORD;
        a_lo      = 2'b10;
        wdata_rep = {2{wdata[15:0]}};
      end
      (sel == 4'b1000): begin
        siz       = SIZ_BYTE;
        wdata_rep = {4{wdata[31:24]}};
      end
      (sel == 4'b0100): begin
        siz       = SIZ_BYTE;
        a_lo      = 2'b01;
        wdata_rep = {4{wdata[23:16]}};
      end
      (sel == 4'b0010): begin
        siz       = SIZ_BYTE;
        a_lo      = 2'b10;
        wdata_rep = {4{wdata[15:8]}};
      end
      (sel == 4'b0001): begin
        siz       = SIZ_BYTE;
        a_lo      = 2'b11;
        wdata_rep = {4{wdata[7:0]}};
      end
      default: legal = 1'b0;
    endcase
  end

  assign mask = {{8{sel[3]}}, {8{sel[2]}},
                 {8{sel[1]}}, {8{sel[0]}}};

  assign rdata_ext = rdata_raw & mask;

endmodule

// File: rtl/m68k_bus_master.sv
// Wishbone-to-68040 single-transfer bus initiator with BR/BG/BB
// arbitration, ta/tea termination and a post-ts timeout.
module m68k_bus_master
  import m68k_bus_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [2:0] TM_DEFAULT     = TM_USER_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data,
  input  logic [3:0]  wb_sel,
  output logic        wb_stall,
  output logic        wb_ack,
  output logic        wb_err,
  output logic [31:0] wb_rdata,
  output logic        br,
  input  logic        bg,
  output logic        bb_o,
  output logic        bb_oe,
  input  logic        bb_i,
  output logic [31:0] a,
  output logic        a_oe,
  output logic [31:0] d_o,
  input  logic [31:0] d_i,
  output logic        d_oe,
  output logic        ts,
  output logic        tip,
  output logic        rw,
  output logic [1:0]  siz,
  output logic [1:0]  tt,
  output logic [2:0]  tm,
  input  logic        ta,
  input  logic        tea,
  output logic        attr_oe
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;

  logic [31:2]   addr_q;
  logic [31:0]   data_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic [CW-1:0] cnt_q;
  logic          ok_q;
  logic          drop_q;
  logic [31:0]   rdata_q;

  logic [3:0]  map_sel;
  logic        map_legal;
  logic [1:0]  map_siz;
  logic [1:0]  map_a_lo;
  logic [31:0] map_wdata;
  logic [31:0] map_rdata;
  logic        accept;
  logic        live;

  // byte offset is carried by wb_sel
  logic unused_addr_lo;
  assign unused_addr_lo = ^wb_addr[1:0];

  // legality is judged on the live request
  assign map_sel = (state_q == S_IDLE) ? wb_sel : sel_q;
  assign accept  = (state_q == S_IDLE) && wb_cyc && wb_stb;
  assign live    = wb_cyc && !drop_q;

  m68k_lane_map u_lane_map (
    .sel       (map_sel),
    .wdata     (data_q),
    .rdata_raw (d_i),
    .legal     (map_legal),
    .siz       (map_siz),
    .a_lo      (map_a_lo),
    .wdata_rep (map_wdata),
    .rdata_ext (map_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      drop_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= wb_addr[31:2];
        data_q <= wb_data;
        sel_q  <= wb_sel;
        we_q   <= wb_we;
        ok_q   <= 1'b0;
        drop_q <= 1'b0;
      end else if (state_q != S_IDLE && !wb_cyc) begin
        drop_q <= 1'b1;
      end
      // cnt_q = clocks elapsed since ts
      if (state_q == S_ADDR) begin
        cnt_q <= CW'(1);
      end else if (state_q == S_DATA) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
      if (state_q == S_DATA && tea && !ta) begin
        ok_q <= 1'b1;
        if (!we_q) begin
          rdata_q <= map_rdata;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    br      = 1'b1;
    ts      = 1'b1;
    tip     = 1'b1;
    bb_o    = 1'b1;
    bb_oe   = 1'b0;
    a_oe    = 1'b0;
    attr_oe = 1'b0;
    d_oe    = 1'b0;
    wb_ack  = 1'b0;
    wb_err  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = map_legal ? S_REQ : S_FAIL;
        end
      end
      S_REQ: begin
        br = 1'b0;
        if (!bg && bb_i) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        ts      = 1'b0;
        tip     = 1'b0;
        bb_o    = 1'b0;
        bb_oe   = 1'b1;
        a_oe    = 1'b1;
        attr_oe = 1'b1;
        state_d = S_DATA;
      end
      S_DATA: begin
        tip     = 1'b0;
        bb_o    = 1'b0;
        bb_oe   = 1'b1;
        a_oe    = 1'b1;
        attr_oe = 1'b1;
        d_oe    = we_q;
        if (!tea || !ta || cnt_q == CNT_LAST) begin
          state_d = S_END;
        end
      end
      S_END: begin
        bb_oe   = 1'b1;
        a_oe    = 1'b1;
        attr_oe = 1'b1;
        wb_ack  = ok_q && live;
        wb_err  = !ok_q && live;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        wb_err  = live;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wb_stall = (state_q != S_IDLE);
  assign wb_rdata = rdata_q;
  assign a        = {addr_q, map_a_lo};
  assign d_o      = map_wdata;
  assign rw       = !we_q;
  assign siz      = map_siz;
  assign tt       = TT_NORMAL;
  assign tm       = TM_DEFAULT;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Scoreboard bench for m68k_bus_master: randomized Wishbone requests,
// modelled arbiter and responder, monitor-side response checking.
module tb_m68k_bus_master;

  localparam int TO = 8;

  logic        clk, rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr, wb_data;
  logic [3:0]  wb_sel;
  logic        wb_stall, wb_ack, wb_err;
  logic [31:0] wb_rdata;
  logic        br, bg, bb_o, bb_oe, bb_i;
  logic [31:0] a, d_o, d_i;
  logic        a_oe, d_oe, ts, tip, rw;
  logic [1:0]  siz, tt;
  logic [2:0]  tm;
  logic        ta, tea, attr_oe;

  m68k_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_sel(wb_sel),
    .wb_stall(wb_stall), .wb_ack(wb_ack), .wb_err(wb_err),
    .wb_rdata(wb_rdata),
    .br(br), .bg(bg), .bb_o(bb_o), .bb_oe(bb_oe), .bb_i(bb_i),
    .a(a), .a_oe(a_oe), .d_o(d_o), .d_i(d_i), .d_oe(d_oe),
    .ts(ts), .tip(tip), .rw(rw), .siz(siz), .tt(tt), .tm(tm),
    .ta(ta), .tea(tea), .attr_oe(attr_oe)
  );

  typedef struct {
    bit          is_err;
    bit          chk;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic        exp_we;
  logic [31:0] exp_a, exp_do;
  logic [1:0]  exp_siz;
  int          exp_dc;
  int          rsp_wait;
  bit          rsp_ta, rsp_tea;
  logic [31:0] rsp_d;
  int          gnt_delay = 0;
  bit          bus_act;

  logic [3:0] legal_sels [7] =
    '{4'hF, 4'hC, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] lane(input logic [31:0] w,
                                      input int l);
    return w[31-8*l -: 8];
  endfunction

  // Reference: lanes numbered 0..3 from D31:24; sel bit 3-L is lane L.
  function automatic void model(input logic [3:0] sel,
                                input logic [31:0] data,
                                input logic [31:0] rd,
                                output bit legal,
                                output logic [1:0] sz,
                                output logic [1:0] alo,
                                output logic [31:0] rep,
                                output logic [31:0] rx);
    int n, l0, nn;
    n  = $countones(sel);
    l0 = 0;
    for (int l = 3; l >= 0; l--) if (sel[3-l]) l0 = l;
    legal = (n == 4) || (n == 1) ||
            (n == 2 && (l0 % 2 == 0) && sel[2-l0]);
    sz  = (n == 4) ? 2'b00 : (n == 2) ? 2'b10 : 2'b01;
    alo = 2'(l0);
    nn  = (n == 0) ? 1 : n;
    rep = '0;
    rx  = '0;
    for (int i = 0; i < 4; i++) begin
      rep[31-8*i -: 8] = lane(data, l0 + (i % nn));
      if (sel[3-i]) rx[31-8*i -: 8] = lane(rd, i);
    end
  endfunction

  // Arbiter: grant after gnt_delay clocks of br low.
  initial begin
    int req_cnt;
    req_cnt = 0;
    bg = 1;
    forever begin
      @(negedge clk);
      if (!br) begin
        bg = (req_cnt >= gnt_delay) ? 1'b0 : 1'b1;
        req_cnt++;
      end else begin
        req_cnt = 0;
        bg = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!br || !ts || a_oe || d_oe || bb_oe || attr_oe)
        bus_act = 1;
    end
  end

  // Responder: checks the bus cycle and terminates it.
  initial begin
    int dc;
    ta = 1; tea = 1; d_i = '0;
    forever begin
      @(negedge clk);
      if (rst && !ts) begin
        check("addr", a, exp_a);
        check("siz", 32'(siz), 32'(exp_siz));
        check("rw", 32'(rw), 32'(!exp_we));
        check("tt_tm", {tt, tm}, 5'b00001);
        check("addr_ctl",
              {br, tip, bb_o, bb_oe, a_oe, attr_oe, d_oe},
              7'b1001110);
        dc = 0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (!rst || tip) break;
          dc++;
          check("data_ctl", {ts, bb_o, d_oe},
                {2'b10, exp_we});
          if (exp_we) check("d_o", d_o, exp_do);
          if (k == rsp_wait && (rsp_ta || rsp_tea)) begin
            ta  = !rsp_ta;
            tea = !rsp_tea;
            d_i = rsp_d;
          end else begin
            ta  = 1;
            tea = 1;
            d_i = $urandom;
          end
        end
        ta = 1; tea = 1; d_i = $urandom;
        if (rst) begin
          check("data_cycles", dc, exp_dc);
          check("end_ctl",
                {ts, tip, bb_o, bb_oe, a_oe, attr_oe, d_oe},
                7'b1111110);
          @(negedge clk);
          if (rst)
            check("release", {bb_oe, a_oe, attr_oe, d_oe, br},
                  5'b00001);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every response pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (wb_ack || wb_err)) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_resp: got ack=%b err=%b expected none",
                   wb_ack, wb_err);
        end else begin
          e = sb.pop_front();
          check("resp_both", {wb_ack, wb_err},
                {!e.is_err, e.is_err});
          if (e.chk) check("rdata", wb_rdata, e.rdata);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string nm);
    check(nm, {br, ts, tip, bb_o, bb_oe, a_oe, d_oe, attr_oe,
               wb_ack, wb_err, wb_stall},
          11'b11110000000);
    check({nm, "_rdata"}, wb_rdata, 32'h0);
  endtask

  // mode 0: normal, 1: drop wb_cyc after accept, 2: reset in DATA
  task automatic run(input bit we, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] sel,
                     input int g, input int w, input bit rta,
                     input bit rtea, input logic [31:0] rd,
                     input int mode);
    bit legal;
    logic [1:0] sz, alo;
    logic [31:0] rep, rx;
    int dc, lat, exp_lat, seen;
    exp_t e;
    model(sel, data, rd, legal, sz, alo, rep, rx);
    dc      = (rta || rtea) ? w + 1 : TO - 1;
    exp_lat = legal ? 3 + g + dc : 1;
    exp_we  = we;
    exp_a   = {addr[31:2], alo};
    exp_siz = sz;
    exp_do  = rep;
    exp_dc  = dc;
    rsp_wait = w; rsp_ta = rta; rsp_tea = rtea; rsp_d = rd;
    gnt_delay = g;
    bus_act = 0;
    if (mode == 0) begin
      e.is_err = !legal || rtea || !rta;
      e.chk    = !we && !e.is_err;
      e.rdata  = rx;
      sb.push_back(e);
    end
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = we;
    wb_addr = addr; wb_data = data; wb_sel = sel;
    @(posedge clk);
    @(negedge clk);
    wb_stb = 0;
    lat = 1;
    if (mode == 0) begin
      while (!(wb_ack || wb_err) && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      check("latency", lat, exp_lat);
      if (!legal) check("no_bus", 32'(bus_act), 32'(0));
      @(posedge clk);
      #1 wb_cyc = 0;
    end else if (mode == 1) begin
      wb_cyc = 0;
      seen = 0;
      repeat (exp_lat + 2) begin
        if (wb_ack || wb_err) seen++;
        @(negedge clk);
      end
      check("dropped_ack", seen, 0);
    end else begin
      lat = 0;
      while (!(!tip && ts) && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("reached_data", {tip, ts, d_oe}, 3'b011);
      #2 rst = 0;
      #1 check_idle_outputs("async_reset");
      wb_cyc = 0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit we, rta, rtea;
    logic [3:0] sel;
    rst = 0; bb_i = 1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    wb_addr = '0; wb_data = '0; wb_sel = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
    @(posedge clk);
    #1 rst = 1;
    repeat (2) @(negedge clk);

    run(0, 32'h3000_0010, 32'h0, 4'hF, 0, 0, 1, 0,
        32'hDEAD_BEEF, 0);
    run(1, 32'h2000_0000, 32'h0000_5A00, 4'b0010, 0, 1, 1, 0,
        32'h0, 0);
    run(1, 32'h1000_0004, 32'h1234_5678, 4'b0110, 0, 0, 1, 0,
        32'h0, 0);
    run(0, 32'h4000_0000, 32'h0, 4'hF, 0, 0, 0, 0, 32'h0, 0);
    run(0, 32'h5000_0002, 32'h0, 4'b0011, 0, 0, 1, 1,
        32'hCAFE_F00D, 0);
    run(0, 32'h5000_0000, 32'h0, 4'b1100, 10, 2, 1, 0,
        32'hA5C3_0F96, 0);
    run(0, 32'h6000_0000, 32'h0, 4'hF, 1, 1, 1, 0,
        32'h1111_2222, 1);
    run(1, 32'h7000_0000, 32'h89AB_CDEF, 4'hF, 0, 0, 0, 0,
        32'h0, 2);
    repeat (2) @(negedge clk);
    check_idle_outputs("after_reset");
    run(0, 32'h3000_0100, 32'h0, 4'b0100, 0, 0, 1, 0,
        32'h0102_0304, 0);

    for (int i = 0; i < 60; i++) begin
      we  = 1'($urandom);
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom)
                                        : legal_sels[$urandom_range(0, 6)];
      k    = $urandom_range(0, 9);
      rta  = (k <= 6) || (k == 8);
      rtea = (k == 7) || (k == 8);
      run(we, $urandom, $urandom, sel, $urandom_range(0, 3),
          $urandom_range(0, 5), rta, rtea, $urandom, 0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
